// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell processes one operand bit per cycle, LSB first.
// Optional signed-overflow tracking is built only when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          c_out_q, c_out_d;

  logic a_bit, b_bit, fa_sum, fa_carry, last_bit;

  // The single full-adder cell shared by every bit position.
  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q];
    fa_sum   = a_bit ^ b_bit ^ carry_q;
    fa_carry = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
    last_bit = (cnt_q == CntLast);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Subtract is a + ~b + 1, so invert b and seed the carry with 1.
          a_d     = a;
          b_d     = op ? ~b : b;
          carry_d = op ? 1'b1 : c_in;
          cnt_d   = '0;
          shift_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        carry_d = fa_carry;
        shift_d = {fa_sum, shift_q[N-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          cnt_d   = '0;
          sum_d   = {fa_sum, shift_q[N-1:1]};
          c_out_d = fa_carry;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == StRun && last_bit) begin
      ovf_q <= carry_q ^ fa_carry;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign ready = (state_q == StIdle);
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at N=16.
// Expected overflow follows SERIAL_ADD_OVF_EN when the bench is built with it.
module tb_serial_add_ctrl;

  localparam int unsigned N = 16;
`ifdef SERIAL_ADD_OVF_EN
  localparam logic OvfOn = 1'b1;
`else
  localparam logic OvfOn = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         c_out;
  logic         overflow;

  int errors;
  int checks;
  int cyc;

  serial_add_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; inputs are scrambled after acceptance.
  task automatic run_op(input string tag, input logic o, input logic [N-1:0] va,
                        input logic [N-1:0] vb, input logic ci, input logic [N-1:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int busy_cnt;
    logic seen_done;
    busy_cnt  = 0;
    seen_done = 1'b0;
    op = o; a = va; b = vb; c_in = ci; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~va; b = ~vb; op = ~o; c_in = ~ci;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(N));
    check({tag, " done"}, 64'(seen_done), 64'd1);
    check({tag, " sum"}, 64'(sum), 64'(exp_sum));
    check({tag, " c_out"}, 64'(c_out), 64'(exp_cout));
    check({tag, " overflow"}, 64'(overflow), 64'(exp_ovf & OvfOn));
    @(negedge clk);
    check({tag, " ready_after"}, 64'(ready), 64'd1);
    check({tag, " sum_held"}, 64'(sum), 64'(exp_sum));
  endtask

  initial begin
    int busy_seen;
    int done_cnt;
    int d1, d2;
    logic [N-1:0] s1, s2;
    logic got;
    errors = 0;
    checks = 0;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset ready", 64'(ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset c_out", 64'(c_out), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);

    run_op("add_1_1", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_op("add_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_cin", 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op("sub_5_7", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_7_5", 1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0);
    run_op("add_7fff_1", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_8000_1", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // start pulsed during RUN cycle 3 with new operands must be ignored.
    op = 1'b0; a = 16'h1234; b = 16'h1111; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("ignore_start done", 64'(got), 64'd1);
    check("ignore_start sum", 64'(sum), 64'h2345);
    @(negedge clk);
    check("ignore_start ready", 64'(ready), 64'd1);
    @(negedge clk);
    check("ignore_start no_rerun", 64'(busy), 64'd0);

    // Reset at RUN cycle 5 aborts the operation.
    a = 16'h00F0; b = 16'h000F; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort ready", 64'(ready), 64'd1);
    check("abort busy", 64'(busy), 64'd0);
    check("abort sum", 64'(sum), 64'd0);
    check("abort c_out", 64'(c_out), 64'd0);
    done_cnt = 0;
    busy_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_seen++;
    end
    check("abort no_done", 64'(done_cnt), 64'd0);
    check("abort no_busy", 64'(busy_seen), 64'd0);

    // rst and start in the same cycle: rst wins.
    rst = 1'b1; start = 1'b1; a = 16'h0003; b = 16'h0004;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start ready", 64'(ready), 64'd1);
    check("rst_start busy", 64'(busy), 64'd0);

    // start held high: two operations back to back, dones 18 cycles apart.
    op = 1'b0; a = 16'h0100; b = 16'h0023; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 16'h4000; b = 16'h0ABC; c_in = 1'b1;
    d1 = -1; d2 = -1; s1 = '0; s2 = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc; s1 = sum;
        end else begin
          d2 = cyc; s2 = sum;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b gap", 64'(d2 - d1), 64'd18);
    check("b2b sum1", 64'(s1), 64'h0123);
    check("b2b sum2", 64'(s2), 64'h4ABD);
    @(negedge clk);
    check("b2b ready", 64'(ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter N, default 16; operand and result width in bits; legal range 2..64.
REQ-002 Port clk, input, 1; single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1; reset is synchronous and active-high.
REQ-004 Port start, input, 1; request to begin an operation.
REQ-005 Port op, input, 1; 0 = add (a+b+c_in), 1 = subtract (a-b).
REQ-006 Port a, input, N; first operand.
REQ-007 Port b, input, N; second operand.
REQ-008 Port c_in, input, 1; carry seed for add; ignored when op=1.
REQ-009 Port ready, output, 1; high only in IDLE; start accepted only while high.
REQ-010 Port busy, output, 1; high only in RUN.
REQ-011 Port done, output, 1; one-cycle pulse, high only in DONE.
REQ-012 Port sum, output, N; registered result.
REQ-013 Port c_out, output, 1; registered carry out of bit N-1.
REQ-014 Port overflow, output, 1; registered signed-overflow flag (see Configuration).

Function
REQ-015 Datapath: one 1-bit full-adder cell, evaluated once per cycle; no N-bit parallel adder.
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after N RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-017 Accept: start=1 in IDLE at edge k captures a, b, op, and carry seed (op ? 1 : c_in) into internal registers; b captured inverted when op=1.
REQ-018 RUN: bit counter 0..N-1; cycle i adds captured bit i of a and b with the carry register; carry register updated each cycle; result bit shifted into internal shift register, LSB first.
REQ-019 Latency: start accepted at edge k -> busy high for cycles k+1..k+N -> done high in cycle k+N+1 -> ready high in cycle k+N+2.
REQ-020 sum, c_out, overflow update only on the RUN->DONE edge; held unchanged at all other times until the next completion.
REQ-021 Subtract: c_out=1 means no borrow (a>=b unsigned); c_out=0 means borrow.
REQ-022 start while busy or done high is ignored; no queuing.
REQ-023 Input changes on a, b, op, c_in after acceptance have no effect on the operation in progress.
REQ-024 start held high continuously yields back-to-back operations, one accepted every N+2 cycles.
REQ-025 Bit counter reaching N-1 does not wrap into a further RUN cycle; the FSM leaves RUN exactly after bit N-1.

Reset
REQ-026 rst=1 at an edge forces IDLE and clears counter, carry, shift and operand registers.
REQ-027 After reset: ready=1, busy=0, done=0, sum=0, c_out=0, overflow=0.
REQ-028 rst asserted mid-RUN or in DONE aborts the operation; no done pulse is produced and outputs take reset values.
REQ-029 rst and start high in the same cycle: rst wins; start is not accepted.

Configuration
REQ-030 Macro SERIAL_ADD_OVF_EN defined: overflow = carry into bit N-1 XOR carry out of bit N-1, latched per REQ-020.
REQ-031 Macro SERIAL_ADD_OVF_EN undefined: overflow port present, tied 0, and no overflow-tracking register is built.

Verification (N=16)
REQ-032 add a=0x0001, b=0x0001, c_in=0 -> busy 16 cycles, done in cycle 17 after accept, sum=0x0002, c_out=0.
REQ-033 add a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1; also c_in=1, a=b=0 -> sum=0x0001.
REQ-034 sub a=0x0005, b=0x0007, c_in=1 -> sum=0xFFFE, c_out=0 (c_in ignored); sub a=0x0007, b=0x0005 -> sum=0x0002, c_out=1.
REQ-035 add a=0x7FFF, b=0x0001 -> sum=0x8000; overflow=1 with SERIAL_ADD_OVF_EN, 0 without.
REQ-036 start pulsed during RUN cycle 3 with new operands -> ignored, original result delivered; rst at RUN cycle 5 -> next cycle ready=1, busy=0, sum=0, no done pulse.
REQ-037 start held high, two operand sets -> done pulses 18 cycles apart, each sum correct.
